// File: rtl/io_bus_arbiter_if.sv
// Requester-side and device-side signal bundle of the peripheral I/O bus arbiter.
// master = requesters and device (environment), slave = the arbiter itself.
interface io_bus_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic [1:0]      req;
    logic [1:0]      write;
    logic [3:0]      kind;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [1:0]      ack;
    logic [1:0]      err;
    logic [2*DW-1:0] rdata;
    logic            dev_req;
    logic            dev_write;
    logic [1:0]      dev_kind;
    logic [AW-1:0]   dev_addr;
    logic [DW-1:0]   dev_wdata;
    logic            dev_ack;
    logic [DW-1:0]   dev_rdata;

    modport master (
        output req, write, kind, addr, wdata, dev_ack, dev_rdata,
        input  ack, err, rdata, dev_req, dev_write, dev_kind, dev_addr, dev_wdata
    );

    modport slave (
        input  req, write, kind, addr, wdata, dev_ack, dev_rdata,
        output ack, err, rdata, dev_req, dev_write, dev_kind, dev_addr, dev_wdata
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Two-requester round-robin arbiter for the peripheral I/O bus with four-phase
// handshakes on both sides and a device-response timeout.
module io_bus_arbiter #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    io_bus_arbiter_if.slave    bus
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [1:0]            ack_q, ack_d;
    logic [1:0]            err_q, err_d;
    logic [1:0][DW-1:0]    rdata_q, rdata_d;
    logic                  dev_req_q, dev_req_d;
    logic                  dev_write_q, dev_write_d;
    logic [1:0]            dev_kind_q, dev_kind_d;
    logic [AW-1:0]         dev_addr_q, dev_addr_d;
    logic [DW-1:0]         dev_wdata_q, dev_wdata_d;
    logic [TW-1:0]         timer_q, timer_d;

    logic [1:0][1:0]       kind_v;
    logic [1:0][AW-1:0]    addr_v;
    logic [1:0][DW-1:0]    wdata_v;
    logic                  winner;

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign kind_v[gi]  = bus.kind[2*gi +: 2];
        assign addr_v[gi]  = bus.addr[gi*AW +: AW];
        assign wdata_v[gi] = bus.wdata[gi*DW +: DW];
    end

    // The requester that did not win last time has priority when it asks.
    assign winner = bus.req[~last_q] ? ~last_q : last_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        ack_d       = ack_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        dev_req_d   = dev_req_q;
        dev_write_d = dev_write_q;
        dev_kind_d  = dev_kind_q;
        dev_addr_d  = dev_addr_q;
        dev_wdata_d = dev_wdata_q;
        timer_d     = timer_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    owner_d     = winner;
                    last_d      = winner;
                    dev_write_d = bus.write[winner];
                    dev_kind_d  = kind_v[winner];
                    dev_addr_d  = addr_v[winner];
                    dev_wdata_d = wdata_v[winner];
                    dev_req_d   = 1'b1;
                    timer_d     = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                timer_d = timer_q + TW'(1);
                if (bus.dev_ack) begin
                    dev_req_d      = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    if (!dev_write_q) rdata_d[owner_q] = bus.dev_rdata;
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
                    dev_req_d      = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    err_d[owner_q] = 1'b1;
                    if (!dev_write_q) rdata_d[owner_q] = '1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Waiting for dev_ack low as well swallows a late ack after a timeout.
                if (!bus.req[owner_q] && !bus.dev_ack) begin
                    ack_d[owner_q] = 1'b0;
                    err_d[owner_q] = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            ack_q       <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            dev_req_q   <= 1'b0;
            dev_write_q <= 1'b0;
            dev_kind_q  <= '0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            dev_req_q   <= dev_req_d;
            dev_write_q <= dev_write_d;
            dev_kind_q  <= dev_kind_d;
            dev_addr_q  <= dev_addr_d;
            dev_wdata_q <= dev_wdata_d;
            timer_q     <= timer_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.dev_req   = dev_req_q;
    assign bus.dev_write = dev_write_q;
    assign bus.dev_kind  = dev_kind_q;
    assign bus.dev_addr  = dev_addr_q;
    assign bus.dev_wdata = dev_wdata_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: vector table, contention/reset/late-ack sequences and
// randomized transfers checked against a transaction-level round-robin model.
module tb_io_bus_arbiter;
    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    io_bus_arbiter_if #(.DW(16), .AW(16)) bif ();

    io_bus_arbiter #(.DW(16), .AW(16), .TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    int tests = 0;
    int fails = 0;

    // Transaction-level model: who won last, and each requester's visible read result.
    bit          m_last;
    logic [15:0] m_rdata [2];

    bit          f_write [2];
    logic [1:0]  f_kind  [2];
    logic [15:0] f_addr  [2];
    logic [15:0] f_wdata [2];
    logic [15:0] f_rd    [2];
    int          f_lat   [2];

    int          obs_cycles;
    bit          obs_err;
    logic [15:0] obs_rdata;

    typedef struct {
        logic [1:0]  rs;
        bit          write;
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rd;
        int          lat;
        int          exp_cycles;
        bit          exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_fields(input int i);
        bif.write[i]          = f_write[i];
        bif.kind[2*i +: 2]    = f_kind[i];
        bif.addr[16*i +: 16]  = f_addr[i];
        bif.wdata[16*i +: 16] = f_wdata[i];
    endtask

    task automatic apply_reset();
        reset         = 1'b0;
        bif.req       = '0;
        bif.write     = '0;
        bif.kind      = '0;
        bif.addr      = '0;
        bif.wdata     = '0;
        bif.dev_ack   = 1'b0;
        bif.dev_rdata = '0;
        repeat (2) @(negedge clock);
        chk("reset_dev_req", bif.dev_req, 0);
        chk("reset_ack", bif.ack, 0);
        chk("reset_err", bif.err, 0);
        chk("reset_rdata", bif.rdata, 0);
        chk("reset_dev_fields", {bif.dev_write, bif.dev_kind, bif.dev_addr}, 0);
        chk("reset_dev_wdata", bif.dev_wdata, 0);
        reset      = 1'b1;
        m_last     = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
    endtask

    // Raise the requests in rs and serve every resulting transfer to completion.
    task automatic serve(input logic [1:0] rs);
        logic [1:0] pend;
        bit         w;
        bit         exp_err;
        int         n, k, exp_cycles;
        pend = rs;
        for (int i = 0; i < 2; i++) begin
            if (rs[i]) begin
                drive_fields(i);
                bif.req[i] = 1'b1;
            end
        end
        while (pend != 2'b00) begin
            w = pend[~m_last] ? ~m_last : m_last;
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!bif.dev_req && n < 10);
            chk("grant_latency", n, 1);
            if (!bif.dev_req) return;
            chk("dev_addr", bif.dev_addr, f_addr[w]);
            chk("dev_write", bif.dev_write, f_write[w]);
            chk("dev_kind", bif.dev_kind, f_kind[w]);
            chk("dev_wdata", bif.dev_wdata, f_wdata[w]);
            m_last     = w;
            exp_err    = (f_lat[w] >= TO);
            exp_cycles = exp_err ? TO : f_lat[w] + 1;
            k = 0;
            while (!bif.ack[w] && k < 20) begin
                if (k == f_lat[w]) begin
                    bif.dev_ack   = 1'b1;
                    bif.dev_rdata = f_rd[w];
                end else if (!bif.dev_ack) begin
                    bif.dev_rdata = 16'($urandom);
                end
                @(negedge clock);
                k++;
            end
            if (!f_write[w]) m_rdata[w] = exp_err ? 16'hFFFF : f_rd[w];
            obs_cycles = k;
            obs_err    = bif.err[w];
            obs_rdata  = bif.rdata[16*w +: 16];
            chk("ack_cycles", k, exp_cycles);
            chk("err", bif.err[w], exp_err);
            chk("dev_req_low", bif.dev_req, 0);
            chk("rdata0", bif.rdata[15:0], m_rdata[0]);
            chk("rdata1", bif.rdata[31:16], m_rdata[1]);
            chk("other_ack", {bif.ack[~w], bif.err[~w]}, 0);
            $display("[TB] txn owner=%0d write=%0d kind=%0d addr=0x%04h lat=%0d ack_after=%0d err=%0d rdata=0x%04h",
                     w, f_write[w], f_kind[w], f_addr[w], f_lat[w], k, obs_err, obs_rdata);
            bif.req[w]  = 1'b0;
            bif.dev_ack = 1'b0;
            @(negedge clock);
            chk("ack_clear", bif.ack[w], 0);
            chk("err_clear", bif.err[w], 0);
            chk("dead_cycle", bif.dev_req, 0);
            pend[w] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int o;
        int exp_o;
        int n;
        vt[0] = '{2'b01, 1'b0, 2'd1, 16'h0000, 16'h0000, 16'h1234, 3, 4, 1'b0, 16'h1234};
        vt[1] = '{2'b10, 1'b1, 2'd2, 16'h0005, 16'hBEEF, 16'h5555, 1, 2, 1'b0, 16'h0000};
        vt[2] = '{2'b01, 1'b0, 2'd0, 16'h0003, 16'h0000, 16'h4321, 9, 8, 1'b1, 16'hFFFF};
        vt[3] = '{2'b10, 1'b0, 2'd3, 16'h0100, 16'h0000, 16'h0F0F, 7, 8, 1'b0, 16'h0F0F};
        vt[4] = '{2'b01, 1'b0, 2'd1, 16'h0042, 16'h0000, 16'hCAFE, 0, 1, 1'b0, 16'hCAFE};
        vt[5] = '{2'b10, 1'b0, 2'd0, 16'h0007, 16'h0000, 16'h1357, 8, 8, 1'b1, 16'hFFFF};
        vt[6] = '{2'b01, 1'b1, 2'd2, 16'h0099, 16'h1111, 16'h2468, 8, 8, 1'b1, 16'hCAFE};

        apply_reset();

        // Single-requester vectors, run back to back from reset.
        for (int i = 0; i < 7; i++) begin
            o          = vt[i].rs[1] ? 1 : 0;
            f_write[o] = vt[i].write;
            f_kind[o]  = vt[i].kind;
            f_addr[o]  = vt[i].addr;
            f_wdata[o] = vt[i].wdata;
            f_rd[o]    = vt[i].rd;
            f_lat[o]   = vt[i].lat;
            serve(vt[i].rs);
            chk("vec_cycles", obs_cycles, vt[i].exp_cycles);
            chk("vec_err", obs_err, vt[i].exp_err);
            chk("vec_rdata", obs_rdata, vt[i].exp_rdata);
        end

        // Continuous contention from reset: grants must alternate 0,1,0,1.
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            f_write[i] = 1'b0;
            f_kind[i]  = 2'd0;
            f_addr[i]  = (i == 0) ? 16'h0A0A : 16'h0B0B;
            f_wdata[i] = '0;
            drive_fields(i);
        end
        bif.req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_o = g % 2;
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!bif.dev_req && n < 10);
            chk("rr_order", bif.dev_addr, (exp_o == 0) ? 16'h0A0A : 16'h0B0B);
            $display("[TB] rr grant %0d dev_addr=0x%04h", g, bif.dev_addr);
            bif.dev_ack   = 1'b1;
            bif.dev_rdata = 16'h0100 + 16'(g);
            @(negedge clock);
            chk("rr_ack", bif.ack[exp_o], 1);
            bif.req[exp_o] = 1'b0;
            bif.dev_ack    = 1'b0;
            @(negedge clock);
            bif.req[exp_o] = 1'b1;
        end
        bif.req = 2'b00;

        // Randomized transfers against the model.
        apply_reset();
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 2; i++) begin
                f_write[i] = 1'($urandom);
                f_kind[i]  = 2'($urandom);
                f_addr[i]  = 16'($urandom);
                f_wdata[i] = 16'($urandom);
                f_rd[i]    = 16'($urandom);
                f_lat[i]   = $urandom_range(0, 10);
            end
            serve(2'($urandom_range(1, 3)));
        end

        // Reset while BUSY: outputs clear at once, held request is regranted.
        apply_reset();
        f_write[0] = 1'b0; f_kind[0] = 2'd1; f_addr[0] = 16'h0033; f_wdata[0] = '0;
        drive_fields(0);
        bif.req = 2'b01;
        @(negedge clock);
        chk("t5_busy", bif.dev_req, 1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_dev_req", bif.dev_req, 0);
        chk("t5_async_outs", {bif.ack, bif.err, bif.dev_kind, bif.dev_addr}, 0);
        chk("t5_async_rdata", bif.rdata, 0);
        @(negedge clock);
        reset  = 1'b1;
        m_last = 1'b1;
        @(negedge clock);
        chk("t5_regrant", bif.dev_req, 1);
        chk("t5_regrant_addr", bif.dev_addr, 16'h0033);
        bif.dev_ack   = 1'b1;
        bif.dev_rdata = 16'h5A5A;
        @(negedge clock);
        chk("t5_ack", bif.ack[0], 1);
        chk("t5_rdata", bif.rdata[15:0], 16'h5A5A);
        $display("[TB] txn reset-mid-busy regrant rdata=0x%04h", bif.rdata[15:0]);
        bif.req     = 2'b00;
        bif.dev_ack = 1'b0;
        @(negedge clock);
        chk("t5_ack_clear", bif.ack[0], 0);

        // Timeout followed by a late, held dev_ack that must be absorbed.
        apply_reset();
        f_write[0] = 1'b0; f_kind[0] = 2'd0; f_addr[0] = 16'h0010; f_wdata[0] = '0;
        f_write[1] = 1'b1; f_kind[1] = 2'd2; f_addr[1] = 16'h0021; f_wdata[1] = 16'h7777;
        drive_fields(0);
        bif.req = 2'b01;
        @(negedge clock);
        chk("t6_grant", bif.dev_req, 1);
        for (int c = 1; c <= TO; c++) begin
            @(negedge clock);
            chk("t6_ack_timing", bif.ack[0], (c == TO));
        end
        chk("t6_err", bif.err[0], 1);
        chk("t6_rdata", bif.rdata[15:0], 16'hFFFF);
        chk("t6_dev_req_low", bif.dev_req, 0);
        $display("[TB] txn timeout owner=0 err=%0d rdata=0x%04h", bif.err[0], bif.rdata[15:0]);
        bif.dev_ack = 1'b1;
        bif.req[0]  = 1'b0;
        drive_fields(1);
        bif.req[1]  = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk("t6_hold_ack", {bif.ack[0], bif.err[0]}, 2'b11);
            chk("t6_no_grant", bif.dev_req, 0);
        end
        bif.dev_ack = 1'b0;
        @(negedge clock);
        chk("t6_ack_clear", {bif.ack[0], bif.err[0]}, 0);
        chk("t6_dead_cycle", bif.dev_req, 0);
        @(negedge clock);
        chk("t6_next_grant", bif.dev_req, 1);
        chk("t6_next_addr", bif.dev_addr, 16'h0021);
        chk("t6_next_write", {bif.dev_write, bif.dev_kind, bif.dev_wdata}, {1'b1, 2'd2, 16'h7777});
        bif.dev_ack   = 1'b1;
        bif.dev_rdata = 16'h9999;
        @(negedge clock);
        chk("t6_r1_ack", {bif.ack[1], bif.err[1]}, 2'b10);
        chk("t6_r1_rdata", bif.rdata[31:16], 16'h0000);
        $display("[TB] txn late-ack absorbed, owner=1 write ack=%0d", bif.ack[1]);
        bif.req     = 2'b00;
        bif.dev_ack = 1'b0;
        @(negedge clock);
        chk("t6_r1_clear", bif.ack[1], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
